instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the control decoder. Holds the program counter, drives the instruction-memory address, and registers the returned word into `Instr`, which feeds the decoder's `instr` input. Redirects on taken branches with a one-cycle squash. Sequences the run as IDLE → RUN → HALT and signals completion on `Done`.

---
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage that sits directly in front of the control decoder.
// It owns the program counter and drives it out as the instruction-memory
// address. It registers the returned word into Instr for the decoder, and
// redirects on taken branches. A redirect squashes the word fetched in the
// same cycle, which costs one bubble. The run is sequenced IDLE -> RUN -> HALT,
// and Done is held high while halted.
//
// Optional feature: define INSTR_FETCH_CYCLE_COUNT_EN to build the saturating
// RUN-cycle counter. Without it, CycleCount is tied to zero.
//
// Ports:
//   Clk         in   1    clock, all state updates on the rising edge
//   Reset       in   1    synchronous active-low reset
//   Start       in   1    begin a run from PC 0 (from IDLE or HALT)
//   Stall       in   1    freeze PC, Instr and InstrValid for the cycle
//   Branch      in   1    decoder flags Instr as a branch
//   Taken       in   1    branch condition true (qualified by Branch)
//   Target      in   PCW  absolute branch target
//   IMemData    in   IW   combinational read data for IMemAddr
//   IMemAddr    out  PCW  current PC
//   Instr       out  IW   registered instruction for the decoder
//   InstrValid  out  1    Instr holds a live instruction
//   Done        out  1    high while in HALT
//   CycleCount  out  32   RUN-cycle counter (zero when the feature is off)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int             IW      = 9,
    parameter int             PCW     = 10,
    parameter logic [IW-1:0]  HALT_OP = 9'h1FF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            Taken,
    input  logic [PCW-1:0]  Target,
    input  logic [IW-1:0]   IMemData,
    output logic [PCW-1:0]  IMemAddr,
    output logic [IW-1:0]   Instr,
    output logic            InstrValid,
    output logic            Done,
    output logic [31:0]     CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    // Halt and branch decisions look at the word already sitting in Instr.
    // Halt outranks a branch flagged in the same cycle.
    logic haltSeen;
    logic branchTaken;

    assign haltSeen    = valid_q && (instr_q == HALT_OP);
    assign branchTaken = valid_q && Branch && Taken;

    // Next-state logic for the fetch sequencer. A stalled RUN cycle keeps
    // every register, so any pending halt or branch is acted on in the first
    // unstalled cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end
            end

            RUN: begin
                if (!Stall) begin
                    if (haltSeen) begin
                        // PC freezes where it is; nothing more is fetched.
                        state_d = HALT;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (branchTaken) begin
                        // The word read this cycle is on the wrong path, so
                        // it is captured but marked invalid (the bubble).
                        pc_d    = Target;
                        instr_d = IMemData;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + PCW'(1);
                        instr_d = IMemData;
                        valid_d = 1'b1;
                    end
                end
            end

            HALT: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = '0;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers. Reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign IMemAddr   = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;

`ifdef INSTR_FETCH_CYCLE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts every cycle spent in RUN, stalls and bubbles included. It
    // saturates at all-ones and is cleared when a halted run restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == HALT && Start) begin
            cnt_d = '0;
        end else if (state_q == RUN && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CycleCount = cnt_q;
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed testbench for instr_fetch. A behavioural instruction memory feeds
// IMemData combinationally. Expected values are hand-computed constants. The
// default memory contents are ((addr*3+5) & 8'hFF), which never equals
// HALT_OP. Selected words are overridden per scenario.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic        Branch;
    logic        Taken;
    logic [9:0]  Target;
    logic [8:0]  IMemData;
    logic [9:0]  IMemAddr;
    logic [8:0]  Instr;
    logic        InstrValid;
    logic        Done;
    logic [31:0] CycleCount;

    logic [8:0]  mem [0:1023];

    int compareCount;
    int mismatchCount;

`ifdef INSTR_FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    instr_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .Branch     (Branch),
        .Taken      (Taken),
        .Target     (Target),
        .IMemData   (IMemData),
        .IMemAddr   (IMemAddr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    assign IMemData = mem[IMemAddr];

    // 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sl, input logic br,
                                 input logic tk, input logic [9:0] tg);
        Start  = st;
        Stall  = sl;
        Branch = br;
        Taken  = tk;
        Target = tg;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expCnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 9'((i * 3 + 5) & 8'hFF);
        mem[0]  = 9'h001;
        mem[1]  = 9'h002;
        mem[2]  = 9'h003;
        mem[3]  = 9'h1FF;
        mem[10] = 9'h0AA;

        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        tick();
        tick();
        checkOutput("reset_addr",  32'(IMemAddr), 32'd0);
        checkOutput("reset_instr", 32'(Instr), 32'd0);
        checkOutput("reset_valid", 32'(InstrValid), 32'd0);
        checkOutput("reset_done",  32'(Done), 32'd0);
        checkOutput("reset_cnt",   CycleCount, 32'd0);

        // IDLE holds without Start.
        Reset = 1'b1;
        tick();
        checkOutput("idle_addr",  32'(IMemAddr), 32'd0);
        checkOutput("idle_valid", 32'(InstrValid), 32'd0);

        // Straight-line run to HALT_OP.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        tick();
        Start = 1'b0;
        checkOutput("start_addr", 32'(IMemAddr), 32'd0);
        checkOutput("start_valid", 32'(InstrValid), 32'd0);
        tick();
        checkOutput("run_instr0", 32'(Instr), 32'h001);
        checkOutput("run_valid0", 32'(InstrValid), 32'd1);
        checkOutput("run_addr0",  32'(IMemAddr), 32'd1);
        tick();
        checkOutput("run_instr1", 32'(Instr), 32'h002);
        tick();
        checkOutput("run_instr2", 32'(Instr), 32'h003);
        checkOutput("run_addr2",  32'(IMemAddr), 32'd3);
        tick();
        checkOutput("run_instr3", 32'(Instr), 32'h1FF);
        checkOutput("run_done3",  32'(Done), 32'd0);
        tick();
        checkOutput("halt_done",  32'(Done), 32'd1);
        checkOutput("halt_valid", 32'(InstrValid), 32'd0);
        checkOutput("halt_addr",  32'(IMemAddr), 32'd4);
        checkOutput("halt_cnt",   CycleCount, expCnt(5));
        tick();
        checkOutput("halt_hold_addr", 32'(IMemAddr), 32'd4);
        checkOutput("halt_hold_cnt",  CycleCount, expCnt(5));

        // Restart from HALT, then take a branch at address 2 to 10.
        mem[3] = 9'h004;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checkOutput("restart_done", 32'(Done), 32'd0);
        checkOutput("restart_addr", 32'(IMemAddr), 32'd0);
        checkOutput("restart_cnt",  CycleCount, 32'd0);
        tick();
        checkOutput("restart_instr0", 32'(Instr), 32'h001);
        tick();
        tick();
        checkOutput("br_instr2", 32'(Instr), 32'h003);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd10);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("br_bubble_valid", 32'(InstrValid), 32'd0);
        checkOutput("br_redirect_addr", 32'(IMemAddr), 32'd10);
        tick();
        checkOutput("br_target_instr", 32'(Instr), 32'h0AA);
        checkOutput("br_target_valid", 32'(InstrValid), 32'd1);
        checkOutput("br_target_addr",  32'(IMemAddr), 32'd11);
        checkOutput("br_cnt", CycleCount, expCnt(5));

        // Mid-run reset aborts, and Start is needed to resume.
        Reset = 1'b0;
        tick();
        checkOutput("midrst_addr",  32'(IMemAddr), 32'd0);
        checkOutput("midrst_instr", 32'(Instr), 32'd0);
        checkOutput("midrst_valid", 32'(InstrValid), 32'd0);
        checkOutput("midrst_cnt",   CycleCount, 32'd0);
        Reset = 1'b1;
        tick();
        checkOutput("midrst_idle_addr", 32'(IMemAddr), 32'd0);
        checkOutput("midrst_idle_valid", 32'(InstrValid), 32'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        checkOutput("resume_instr0", 32'(Instr), 32'h001);
        tick();
        tick();
        // A not-taken branch must not create a bubble.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd10);
        tick();
        Branch = 1'b0;
        checkOutput("nt_instr", 32'(Instr), 32'h004);
        checkOutput("nt_valid", 32'(InstrValid), 32'd1);
        checkOutput("nt_addr",  32'(IMemAddr), 32'd4);

        // A taken branch is held under a 3-cycle stall.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd20);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_addr", i), 32'(IMemAddr), 32'd4);
            checkOutput($sformatf("stall%0d_instr", i), 32'(Instr), 32'h004);
            checkOutput($sformatf("stall%0d_valid", i), 32'(InstrValid), 32'd1);
        end
        Stall = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("unstall_addr",  32'(IMemAddr), 32'd20);
        checkOutput("unstall_valid", 32'(InstrValid), 32'd0);
        tick();
        checkOutput("unstall_instr", 32'(Instr), 32'h041);
        checkOutput("unstall_next_addr", 32'(IMemAddr), 32'd21);

        // PC wraps from 1023 to 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd1022);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("wrap_jump_addr", 32'(IMemAddr), 32'd1022);
        tick();
        checkOutput("wrap_instr1022", 32'(Instr), 32'h0FF);
        checkOutput("wrap_addr1023",  32'(IMemAddr), 32'd1023);
        tick();
        checkOutput("wrap_instr1023", 32'(Instr), 32'h002);
        checkOutput("wrap_addr0",     32'(IMemAddr), 32'd0);

        // A stalled halt wins over a simultaneous taken branch.
        Reset = 1'b0;
        tick();
        mem[3] = 9'h1FF;
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("hp_instr", 32'(Instr), 32'h1FF);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd10);
        tick();
        tick();
        checkOutput("hp_stall_done",  32'(Done), 32'd0);
        checkOutput("hp_stall_valid", 32'(InstrValid), 32'd1);
        checkOutput("hp_stall_addr",  32'(IMemAddr), 32'd4);
        Stall = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("hp_done",  32'(Done), 32'd1);
        checkOutput("hp_addr",  32'(IMemAddr), 32'd4);
        checkOutput("hp_valid", 32'(InstrValid), 32'd0);
        checkOutput("hp_cnt",   CycleCount, expCnt(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
